// File: rtl/ip_rewrite_lookup_table.sv
// Flow tuple -> rewrite address lookup table with a two-stage request/response pipeline.
// Table writes land at the clock edge; a compare in the same cycle sees the pre-write contents.
module ip_rewrite_lookup_table #(
   parameter  int TABLE_ENTRIES       = 8,
   localparam int FLOW_LOOKUP_TUPLE_W = 64,
   localparam int IP_ADDR_W           = 32,
   localparam int OCC_W               = $clog2(TABLE_ENTRIES + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [TABLE_ENTRIES-1:0]       lookup_wr_table_val,
   input  logic [FLOW_LOOKUP_TUPLE_W-1:0] lookup_wr_table_tuple,
   input  logic [IP_ADDR_W-1:0]           lookup_wr_table_addr,
   input  logic                           lookup_wr_table_set,
   input  logic                           lookup_rd_req_val,
   input  logic [FLOW_LOOKUP_TUPLE_W-1:0] lookup_rd_req_tuple,
   output logic                           lookup_rd_req_rdy,
   output logic                           lookup_rd_resp_val,
   output logic                           lookup_rd_resp_hit,
   output logic [IP_ADDR_W-1:0]           lookup_rd_resp_addr,
   input  logic                           lookup_rd_resp_rdy,
   output logic [OCC_W-1:0]               lookup_table_occ
);

   logic [TABLE_ENTRIES-1:0]       valid_q, valid_d;
   logic [FLOW_LOOKUP_TUPLE_W-1:0] tag_q  [TABLE_ENTRIES];
   logic [IP_ADDR_W-1:0]           addr_q [TABLE_ENTRIES];
   logic [OCC_W-1:0]               occ_q, occ_d;

   logic                           s1_val_q, s1_val_d;
   logic [FLOW_LOOKUP_TUPLE_W-1:0] s1_tuple_q, s1_tuple_d;
   logic                           s2_val_q, s2_val_d;
   logic                           s2_hit_q, s2_hit_d;
   logic [IP_ADDR_W-1:0]           s2_addr_q, s2_addr_d;

   logic                           s1_adv;
   logic                           s2_xfer;
   logic                           req_acc;
   logic                           hit_c;
   logic [IP_ADDR_W-1:0]           addr_c;

   assign s2_xfer           = s2_val_q & lookup_rd_resp_rdy;
   assign s1_adv            = s1_val_q & (~s2_val_q | lookup_rd_resp_rdy);
   assign lookup_rd_req_rdy = ~s1_val_q | s1_adv;
   assign req_acc           = lookup_rd_req_val & lookup_rd_req_rdy;

   // Scan from the top down so the lowest matching index is the last to assign.
   always_comb begin
      hit_c  = 1'b0;
      addr_c = '0;
      for (int i = TABLE_ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == s1_tuple_q)) begin
            hit_c  = 1'b1;
            addr_c = addr_q[i];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < TABLE_ENTRIES; i++) begin
         if (lookup_wr_table_val[i]) valid_d[i] = lookup_wr_table_set;
      end
      occ_d = '0;
      for (int i = 0; i < TABLE_ENTRIES; i++) begin
         occ_d = occ_d + OCC_W'(valid_d[i]);
      end
   end

   always_comb begin
      s1_val_d   = s1_val_q;
      s1_tuple_d = s1_tuple_q;
      if (req_acc) begin
         s1_val_d   = 1'b1;
         s1_tuple_d = lookup_rd_req_tuple;
      end else if (s1_adv) begin
         s1_val_d   = 1'b0;
      end

      s2_val_d  = s2_val_q;
      s2_hit_d  = s2_hit_q;
      s2_addr_d = s2_addr_q;
      if (s1_adv) begin
         s2_val_d  = 1'b1;
         s2_hit_d  = hit_c;
         s2_addr_d = addr_c;
      end else if (s2_xfer) begin
         s2_val_d  = 1'b0;
         s2_hit_d  = 1'b0;
         s2_addr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         occ_q      <= '0;
         s1_val_q   <= 1'b0;
         s1_tuple_q <= '0;
         s2_val_q   <= 1'b0;
         s2_hit_q   <= 1'b0;
         s2_addr_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         occ_q      <= occ_d;
         s1_val_q   <= s1_val_d;
         s1_tuple_q <= s1_tuple_d;
         s2_val_q   <= s2_val_d;
         s2_hit_q   <= s2_hit_d;
         s2_addr_q  <= s2_addr_d;
      end
   end

   // Tag/address payload is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < TABLE_ENTRIES; i++) begin
         if (lookup_wr_table_val[i] && lookup_wr_table_set) begin
            tag_q[i]  <= lookup_wr_table_tuple;
            addr_q[i] <= lookup_wr_table_addr;
         end
      end
   end

   assign lookup_rd_resp_val  = s2_val_q;
   assign lookup_rd_resp_hit  = s2_hit_q;
   assign lookup_rd_resp_addr = s2_addr_q;
   assign lookup_table_occ    = occ_q;

endmodule

// File: doc/ip_rewrite_lookup_table.md
IP_REWRITE_LOOKUP_TABLE -- requirements
Module: ip_rewrite_lookup_table

Interface
REQ-001 Parameter TABLE_ENTRIES, default 8, SHALL set the number of table entries; legal range 2..64.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port lookup_wr_table_val  input  TABLE_ENTRIES  SHALL carry per-entry write strobes from the table controller.
REQ-005 Port lookup_wr_table_tuple  input  FLOW_LOOKUP_TUPLE_W (64)  SHALL carry the tag {their_addr[31:0], their_port[15:0], our_port[15:0]}.
REQ-006 Port lookup_wr_table_addr  input  IP_ADDR_W (32)  SHALL carry the rewrite address stored with the tag.
REQ-007 Port lookup_wr_table_set  input  1  SHALL select the write type: 1 = set entry valid, 0 = clear entry.
REQ-008 Port lookup_rd_req_val  input  1  SHALL mark a valid lookup request.
REQ-009 Port lookup_rd_req_tuple  input  64  SHALL carry the packet tuple to match.
REQ-010 Port lookup_rd_req_rdy  output  1  SHALL indicate the block accepts a request this cycle.
REQ-011 Port lookup_rd_resp_val  output  1  SHALL mark a valid lookup result.
REQ-012 Port lookup_rd_resp_hit  output  1  SHALL be 1 when the tuple matched a valid entry.
REQ-013 Port lookup_rd_resp_addr  output  32  SHALL carry the matched rewrite address, or 0 on miss.
REQ-014 Port lookup_rd_resp_rdy  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-015 Port lookup_table_occ  output  clog2(TABLE_ENTRIES+1)  SHALL report the number of valid entries.

Function
REQ-016 Storage SHALL be per entry: valid bit, 64-bit tag, 32-bit address, all flops.
REQ-017 On any cycle with lookup_wr_table_val[i]=1 and set=1, entry i SHALL load tag and addr and set valid at that edge.
REQ-018 On a cycle with lookup_wr_table_val[i]=1 and set=0, entry i SHALL clear valid; tag and addr are unchanged.
REQ-019 Non-one-hot strobes SHALL write every flagged entry identically; a zero strobe is a no-op.
REQ-020 Handshake: request transfers when lookup_rd_req_val & lookup_rd_req_rdy; response transfers when lookup_rd_resp_val & lookup_rd_resp_rdy.
REQ-021 Pipeline SHALL have two stages: S1 request register (valid + tuple), S2 response register (val, hit, addr).
REQ-022 S1 SHALL advance into S2 when S1 is valid and (S2 empty or S2 transferring this cycle).
REQ-023 lookup_rd_req_rdy SHALL equal (!S1 valid) | (S1 advancing this cycle); it is combinational.
REQ-024 The compare SHALL be performed as S1 advances, against registered table contents.
REQ-025 Latency: a request accepted at edge N SHALL show resp_val at edge N+1 with no backpressure; full throughput is one lookup per cycle.
REQ-026 Match SHALL require valid=1 and exact 64-bit tag equality.
REQ-027 On multiple matches, the lowest index SHALL win.
REQ-028 On a miss, hit SHALL be 0 and addr 0.
REQ-029 A table write and a compare in the same cycle SHALL have the compare see pre-write contents; the write is visible to compares from the next cycle.
REQ-030 While resp_val=1 and resp_rdy=0, the response fields SHALL hold stable and S1 SHALL hold, with no request dropped or duplicated.
REQ-031 lookup_table_occ SHALL be a registered popcount of valid bits, updated the same edge as the writes.
REQ-032 Setting an already-valid entry SHALL not change occ; clearing an invalid entry SHALL not change occ.

Reset
REQ-033 While rst_n=0, all valid bits, the S1 valid, resp_val, hit, addr and occ SHALL be 0 immediately, independent of clk.
REQ-034 Tag and addr storage need no reset.
REQ-035 Reset asserted mid-operation SHALL discard in-flight requests and responses, with no output after release.
REQ-036 After rst_n release, lookup_rd_req_rdy SHALL be 1 on the first cycle.

Verification
REQ-037 Set entry 2 = {0x0A000001, 0x1F90, 0x0050} with addr 0xC0A80001, then look up the same tuple -> hit=1, addr=0xC0A80001, resp_val one edge after accept; occ=1.
REQ-038 Look up {0x0A000002, 0x1F90, 0x0050} against the table above -> hit=0, addr=0.
REQ-039 Write entry 5 with set=1 in the same cycle as S1 advances for the same tuple -> that response is a miss; an identical request the next cycle -> hit.
REQ-040 Issue 4 back-to-back requests with resp_rdy held 0 for 3 cycles -> rdy deasserts with S1 and S2 full; all 4 responses emerge in order, unchanged while stalled.
REQ-041 Set entries 0 and 3 with the same tag (addrs 0x1, 0x3) -> hit addr=0x1; clear entry 0 -> addr=0x3 and occ goes 2->1.
REQ-042 Assert rst_n=0 with a response pending -> resp_val, occ and valid bits go to 0 asynchronously; after release a lookup of the old tuple misses.
